// File: rtl/read_burst_buffer.sv
// -----------------------------------------------------------------------------
// read_burst_buffer
//
// Collects read-data beats from the PHY read path into complete bursts. Each
// completed burst is stored in a circular set of slots and is tagged with the
// read ID of the READ command that produced it. The ID comes from an in-order
// ID queue that the command side fills as READs are issued.
//
// The PHY read path cannot be back-pressured. If a burst starts while every
// slot is full, all of its beats are discarded. Its ID is still consumed so
// that later bursts keep the correct IDs.
//
// Ports
//   clk         single clock, all logic on its rising edge
//   rst         synchronous, active-high reset
//   inData      one beat from the PHY read path
//   inValid     beat valid
//   inLast      final beat of the burst, as flagged by the PHY
//   bufReady    at least one slot free; the PHY controller gates read-out on it
//   tagValid    push tagId into the ID queue
//   tagId       read ID, pushed in command order
//   tagReady    ID queue is not full
//   lineValid   a completed burst is available
//   lineData    completed burst, beat 0 in the least-significant bits
//   lineId      read ID of the burst on lineData
//   lineReady   consumer accepts the line
//   freeCount   number of free slots
//   errOverflow sticky: a burst arrived with no free slot
//   errFraming  sticky: inLast disagreed with the burst length
//   errNoTag    sticky: a burst ended while the ID queue was empty
// -----------------------------------------------------------------------------
module read_burst_buffer #(
    parameter int MEM_DATAWIDTH = 64,
    parameter int BURST_LENGTH  = 8,
    parameter int NUM_ENTRIES   = 4,
    parameter int ID_WIDTH      = 4,
    parameter int TAG_DEPTH     = 8
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [MEM_DATAWIDTH-1:0]              inData,
    input  logic                                  inValid,
    input  logic                                  inLast,
    output logic                                  bufReady,
    input  logic                                  tagValid,
    input  logic [ID_WIDTH-1:0]                   tagId,
    output logic                                  tagReady,
    output logic                                  lineValid,
    output logic [MEM_DATAWIDTH*BURST_LENGTH-1:0] lineData,
    output logic [ID_WIDTH-1:0]                   lineId,
    input  logic                                  lineReady,
    output logic [$clog2(NUM_ENTRIES+1)-1:0]      freeCount,
    output logic                                  errOverflow,
    output logic                                  errFraming,
    output logic                                  errNoTag
);

    localparam int PTR_W  = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
    localparam int CNT_W  = $clog2(NUM_ENTRIES + 1);
    localparam int BEAT_W = (BURST_LENGTH > 1) ? $clog2(BURST_LENGTH) : 1;
    localparam int TPTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int TCNT_W = $clog2(TAG_DEPTH + 1);

    localparam logic [CNT_W-1:0]  SLOTS_FULL = CNT_W'(NUM_ENTRIES);
    localparam logic [PTR_W-1:0]  LAST_SLOT  = PTR_W'(NUM_ENTRIES - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BURST_LENGTH - 1);
    localparam logic [TPTR_W-1:0] LAST_TAG   = TPTR_W'(TAG_DEPTH - 1);
    localparam logic [TCNT_W-1:0] TAGS_FULL  = TCNT_W'(TAG_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DROP
    } fillState_t;

    // Fill-side state.
    fillState_t                 state_q;
    logic [BEAT_W-1:0]          beatCnt_q;

    // Slot store.
    logic [BURST_LENGTH-1:0][MEM_DATAWIDTH-1:0] slotData_q [NUM_ENTRIES];
    logic [ID_WIDTH-1:0]                        slotId_q   [NUM_ENTRIES];
    logic [PTR_W-1:0]           wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]           rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0]           count_q, count_d;

    // ID queue.
    logic [ID_WIDTH-1:0]        tagMem_q [TAG_DEPTH];
    logic [TPTR_W-1:0]          tagWrPtr_q, tagWrPtr_d;
    logic [TPTR_W-1:0]          tagRdPtr_q, tagRdPtr_d;
    logic [TCNT_W-1:0]          tagCount_q, tagCount_d;

    // Sticky error flags.
    logic                       errOverflow_q;
    logic                       errFraming_q;
    logic                       errNoTag_q;

    // Per-cycle control strobes.
    logic                       slotsFull;
    logic                       dropping;
    logic                       isEndBeat;
    logic                       burstDone;
    logic                       commit;
    logic                       frameErr;
    logic                       overflowHit;
    logic                       tagEmpty;
    logic                       tagPush;
    logic                       tagPop;
    logic                       linePop;
    logic [ID_WIDTH-1:0]        headId;

    // A burst is discarded from its first beat onward if it starts with every
    // slot occupied. The decision uses registered occupancy only, so a line
    // popped in the same cycle cannot rescue that beat. A burst ends on the
    // nominal last beat or on an early inLast, whichever comes first. Every
    // burst end consumes exactly one ID: commit, abort and drop alike.
    always_comb begin
        slotsFull   = (count_q == SLOTS_FULL);
        dropping    = (state_q == DROP) || ((state_q == IDLE) && slotsFull);
        isEndBeat   = (beatCnt_q == LAST_BEAT);
        burstDone   = inValid && (isEndBeat || inLast);
        commit      = inValid && isEndBeat && !dropping;
        frameErr    = inValid && (isEndBeat != inLast);
        overflowHit = inValid && (state_q == IDLE) && slotsFull;
        tagEmpty    = (tagCount_q == '0);
        headId      = tagEmpty ? '0 : tagMem_q[tagRdPtr_q];
        tagPush     = tagValid && tagReady;
        tagPop      = burstDone && !tagEmpty;
        linePop     = lineValid && lineReady;
    end

    // Next-state values for the slot and ID-queue pointers and counters.
    // Pointers wrap explicitly, so a depth that is not a power of two still
    // works.
    always_comb begin
        wrPtr_d = wrPtr_q;
        if (commit) begin
            wrPtr_d = (wrPtr_q == LAST_SLOT) ? '0 : wrPtr_q + 1'b1;
        end

        rdPtr_d = rdPtr_q;
        if (linePop) begin
            rdPtr_d = (rdPtr_q == LAST_SLOT) ? '0 : rdPtr_q + 1'b1;
        end

        count_d = count_q;
        case ({commit, linePop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        tagWrPtr_d = tagWrPtr_q;
        if (tagPush) begin
            tagWrPtr_d = (tagWrPtr_q == LAST_TAG) ? '0 : tagWrPtr_q + 1'b1;
        end

        tagRdPtr_d = tagRdPtr_q;
        if (tagPop) begin
            tagRdPtr_d = (tagRdPtr_q == LAST_TAG) ? '0 : tagRdPtr_q + 1'b1;
        end

        tagCount_d = tagCount_q;
        case ({tagPush, tagPop})
            2'b10:   tagCount_d = tagCount_q + 1'b1;
            2'b01:   tagCount_d = tagCount_q - 1'b1;
            default: tagCount_d = tagCount_q;
        endcase
    end

    // All state updates happen here: the fill FSM, the slot and ID storage,
    // and the sticky flags. Reset also clears the slot data, so lineData
    // reads as zero afterwards. Inputs are ignored during the reset cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            beatCnt_q     <= '0;
            wrPtr_q       <= '0;
            rdPtr_q       <= '0;
            count_q       <= '0;
            tagWrPtr_q    <= '0;
            tagRdPtr_q    <= '0;
            tagCount_q    <= '0;
            errOverflow_q <= 1'b0;
            errFraming_q  <= 1'b0;
            errNoTag_q    <= 1'b0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                slotData_q[i] <= '0;
                slotId_q[i]   <= '0;
            end
            for (int i = 0; i < TAG_DEPTH; i++) begin
                tagMem_q[i] <= '0;
            end
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
            tagWrPtr_q <= tagWrPtr_d;
            tagRdPtr_q <= tagRdPtr_d;
            tagCount_q <= tagCount_d;

            if (inValid && !dropping) begin
                slotData_q[wrPtr_q][beatCnt_q] <= inData;
            end
            if (commit) begin
                slotId_q[wrPtr_q] <= headId;
            end
            if (tagPush) begin
                tagMem_q[tagWrPtr_q] <= tagId;
            end

            if (overflowHit) begin
                errOverflow_q <= 1'b1;
            end
            if (frameErr) begin
                errFraming_q <= 1'b1;
            end
            if (burstDone && tagEmpty) begin
                errNoTag_q <= 1'b1;
            end

            // An aborted partial slot is never committed. The next burst
            // restarts at beat 0 in the same slot and overwrites the stale
            // beats.
            if (inValid) begin
                if (burstDone) begin
                    state_q   <= IDLE;
                    beatCnt_q <= '0;
                end else begin
                    state_q   <= dropping ? DROP : FILL;
                    beatCnt_q <= beatCnt_q + 1'b1;
                end
            end
        end
    end

    assign bufReady    = !slotsFull;
    assign freeCount   = SLOTS_FULL - count_q;
    assign tagReady    = (tagCount_q != TAGS_FULL);
    assign lineValid   = (count_q != '0);
    assign lineData    = slotData_q[rdPtr_q];
    assign lineId      = slotId_q[rdPtr_q];
    assign errOverflow = errOverflow_q;
    assign errFraming  = errFraming_q;
    assign errNoTag    = errNoTag_q;

endmodule
